// File: rtl/rv32_core_pkg.sv
// Shared RV32 core definitions: datapath width, the canonical NOP encoding and
// the fetch-buffer entry layout.
package rv32_core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush, holding {pc, inst} fetch entries.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo
  import rv32_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [2*XLEN-1:0]            wr_data,
  output logic [2*XLEN-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Flush shares the reset path: occupancy and both pointers return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: credit-based prefetch from instruction memory into a
// small FIFO feeding decode. Optional macro FETCH_BUF_BYPASS_EN forwards a response
// straight to decode when the buffer is empty (latency 1 instead of 2).
module inst_fetch_buf
  import rv32_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [XLEN-1:0]              pc_addr,
  input  logic                         redirect,
  output logic                         pc_stall,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [XLEN-1:0]              imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [XLEN-1:0]              id_inst,
  output logic [XLEN-1:0]              id_pc,
  output logic [$clog2(DEPTH+1)-1:0]   buf_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic         inflight;
  logic [XLEN-1:0] req_addr;
  logic [CW:0]  credit_used;
  logic         rsp_valid;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  fetch_entry_t rsp_entry;
  fetch_entry_t fifo_head;
  fetch_entry_t out_entry;

  assign imem_addr = pc_addr;

  // A request is only issued when a slot is guaranteed for its response.
  assign credit_used = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight};
  assign imem_req    = rst_n & ~redirect & (credit_used < (CW+1)'(DEPTH));
  assign pc_stall    = rst_n & ~redirect & ~imem_req;

  // NOTE: reset is synchronous, so it is tested inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      req_addr <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) req_addr <= pc_addr;
    end
  end

  assign rsp_valid = inflight & ~redirect;
  assign rsp_entry = '{pc: req_addr, inst: imem_rdata};

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_valid & fifo_empty;
  // A bypassed response consumed this cycle never occupies a slot.
  assign fifo_push = rsp_valid & ~(bypass & id_ready);
  assign fifo_pop  = ~fifo_empty & id_ready;
  assign id_valid  = rst_n & (~fifo_empty | bypass);
  assign out_entry = fifo_empty ? rsp_entry : fifo_head;
`else
  assign fifo_push = rsp_valid;
  assign fifo_pop  = id_valid & id_ready;
  assign id_valid  = rst_n & ~fifo_empty;
  assign out_entry = fifo_head;
`endif

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    id_inst = NOP_INST;
    id_pc   = '0;
    if (id_valid) begin
      id_inst = out_entry.inst;
      id_pc   = out_entry.pc;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (rsp_entry),
    .rd_data (fifo_head),
    .count   (buf_cnt),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_inst_fetch_buf;
  import rv32_core_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic [31:0]   pc_addr;
  logic          redirect;
  logic          pc_stall;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_inst;
  logic [31:0]   id_pc;
  logic [CW-1:0] buf_cnt;

  inst_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .redirect   (redirect),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .buf_cnt    (buf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: the buffer is a queue of requested addresses, plus one
  // outstanding request slot.
  logic [31:0] mq[$];
  bit          m_inflight = 1'b0;
  logic [31:0] m_req_addr = '0;

  // Environment program counter.
  logic [31:0] pc = '0;

  // Instruction memory contents: unique per address and never equal to NOP.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input bit r_n, input bit redir, input logic [31:0] target, input bit rdy);
    bit          e_req, e_stall, e_valid, a_req;
    logic [31:0] e_pc, e_inst;
    int          sz;
    if (redir) pc = target;
    rst_n    = r_n;
    redirect = redir;
    id_ready = rdy;
    pc_addr  = pc;
    @(negedge clk);
    sz      = mq.size();
    e_req   = r_n && !redir && (sz + int'(m_inflight) < DEPTH);
    e_stall = r_n && !redir && !e_req;
`ifdef FETCH_BUF_BYPASS_EN
    e_valid = r_n && (sz != 0 || (m_inflight && !redir));
`else
    e_valid = r_n && (sz != 0);
`endif
    e_pc   = '0;
    e_inst = NOP_INST;
    if (e_valid) begin
      e_pc   = (sz != 0) ? mq[0] : m_req_addr;
      e_inst = inst_of(e_pc);
    end
    check("imem_req",  64'(imem_req),  64'(e_req));
    check("pc_stall",  64'(pc_stall),  64'(e_stall));
    check("imem_addr", 64'(imem_addr), 64'(pc));
    check("id_valid",  64'(id_valid),  64'(e_valid));
    check("id_pc",     64'(id_pc),     64'(e_pc));
    check("id_inst",   64'(id_inst),   64'(e_inst));
    check("buf_cnt",   64'(buf_cnt),   64'(sz));
    a_req = imem_req;
    @(posedge clk);
    #1;
    cyc++;
    if (!r_n || redir) begin
      mq.delete();
      m_inflight = 1'b0;
    end else begin
      if (m_inflight) mq.push_back(m_req_addr);
      if (e_valid && rdy) void'(mq.pop_front());
      m_inflight = e_req;
      if (e_req) m_req_addr = pc;
    end
    // Memory answers one cycle after a request; otherwise the bus carries junk.
    imem_rdata = a_req ? inst_of(pc_addr) : $urandom();
    if (a_req) pc = pc + 32'd1;
  endtask

  initial begin
    int r;
    rst_n      = 1'b0;
    redirect   = 1'b0;
    id_ready   = 1'b0;
    pc_addr    = '0;
    imem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset held for two cycles.
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming from address 0 with decode always ready.
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure: fill the buffer, release one entry, then drain.
    repeat (7) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with 5,6,7 buffered and 8 in flight.
    cycle(1'b1, 1'b1, 32'h5, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h40, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Wrap-around with decode ready toggling every cycle.
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 32'h0, i[0]);

    // Mid-operation reset while a request is in flight.
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic: occasional redirects and resets, random decode readiness.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 63));
      cycle(r != 0, (r != 0) && (r < 4), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
